sysid_check_ctrl: RTL and testbench

//  Sequencer/arbiter in front of the system-ID slave (1-bit address, 32-bit combinational readdata).

---
 rtl/sysid_check_ctrl.sv | 150 +++++++++++++++
 tb/tb_sysid_check_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_ctrl.sv
// Check sequencer and host arbiter for the system-ID slave: verifies ID/timestamp after reset or on
// recheck, then lends the slave to the host read port. Optional error IRQ: SYSID_CHK_ERR_IRQ_EN.
module sysid_check_ctrl #(
  parameter logic [31:0] EXP_ID  = 32'h2F35ABDF,
  parameter logic [31:0] EXP_TS  = 32'h4D49E0DD,
  parameter int unsigned RD_WAIT = 1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  output logic        sid_address_o,
  input  logic [31:0] sid_readdata_i,
  input  logic        host_read_i,
  input  logic        host_address_i,
  output logic        host_waitrequest_o,
  output logic [31:0] host_readdata_o,
  output logic        host_readdatavalid_o,
  input  logic        recheck_i,
  output logic        check_done_o,
  output logic        id_ok_o,
`ifdef SYSID_CHK_ERR_IRQ_EN
  output logic        ts_ok_o,
  output logic        irq_o,
  input  logic        irq_ack_i
`else
  output logic        ts_ok_o
`endif
);

  typedef enum logic [1:0] {S_CHK_ID, S_CHK_TS, S_IDLE, S_HOST} state_t;

  localparam logic [3:0] CNT_INIT = 4'(RD_WAIT);

  state_t      state_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        sample_d;
  logic        sid_addr_q;
  logic [31:0] rdata_q;
  logic        rvalid_q;
  logic        done_q, id_ok_q, ts_ok_q;
  logic        rchk_pend_q;
  logic        id_match, ts_match;
`ifdef SYSID_CHK_ERR_IRQ_EN
  logic        irq_q;
`endif

  // The slave read completes on the edge where the wait counter has run out.
  assign sample_d = (cnt_q == 4'd0);
  assign cnt_d    = sample_d ? CNT_INIT : (cnt_q - 4'd1);
  assign id_match = (sid_readdata_i == EXP_ID);
  assign ts_match = (sid_readdata_i == EXP_TS);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_CHK_ID;
      cnt_q       <= CNT_INIT;
      sid_addr_q  <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      done_q      <= 1'b0;
      id_ok_q     <= 1'b0;
      ts_ok_q     <= 1'b0;
      rchk_pend_q <= 1'b0;
`ifdef SYSID_CHK_ERR_IRQ_EN
      irq_q       <= 1'b0;
`endif
    end else begin
      rvalid_q <= 1'b0;
`ifdef SYSID_CHK_ERR_IRQ_EN
      if (irq_ack_i) irq_q <= 1'b0;
`endif
      case (state_q)
        S_CHK_ID, S_CHK_TS: begin
          if (recheck_i) begin
            state_q    <= S_CHK_ID;
            cnt_q      <= CNT_INIT;
            sid_addr_q <= 1'b0;
            done_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
            if (sample_d) begin
              if (state_q == S_CHK_ID) begin
                id_ok_q    <= id_match;
                sid_addr_q <= 1'b1;
                state_q    <= S_CHK_TS;
              end else begin
                ts_ok_q <= ts_match;
                done_q  <= 1'b1;
                state_q <= S_IDLE;
`ifdef SYSID_CHK_ERR_IRQ_EN
                // Set beats a same-cycle acknowledge.
                if (!(id_ok_q && ts_match)) irq_q <= 1'b1;
`endif
              end
            end
          end
        end
        S_IDLE: begin
          if (recheck_i) begin
            state_q    <= S_CHK_ID;
            cnt_q      <= CNT_INIT;
            sid_addr_q <= 1'b0;
            done_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
          end else if (host_read_i) begin
            sid_addr_q <= host_address_i;
            cnt_q      <= CNT_INIT;
            state_q    <= S_HOST;
          end
        end
        S_HOST: begin
          // A recheck cannot abort an accepted host read; remember it for afterwards.
          if (recheck_i) begin
            rchk_pend_q <= 1'b1;
            done_q      <= 1'b0;
            id_ok_q     <= 1'b0;
            ts_ok_q     <= 1'b0;
          end
          cnt_q <= cnt_d;
          if (sample_d) begin
            rdata_q  <= sid_readdata_i;
            rvalid_q <= 1'b1;
            if (rchk_pend_q || recheck_i) begin
              rchk_pend_q <= 1'b0;
              sid_addr_q  <= 1'b0;
              state_q     <= S_CHK_ID;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_CHK_ID;
      endcase
    end
  end

  assign sid_address_o        = sid_addr_q;
  assign host_waitrequest_o   = (state_q != S_IDLE) | recheck_i | rchk_pend_q;
  assign host_readdata_o      = rdata_q;
  assign host_readdatavalid_o = rvalid_q;
  assign check_done_o         = done_q;
  assign id_ok_o              = id_ok_q;
  assign ts_ok_o              = ts_ok_q;
`ifdef SYSID_CHK_ERR_IRQ_EN
  assign irq_o                = irq_q;
`endif

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl: dut_a uses RD_WAIT=1, dut_b uses RD_WAIT=2.
module tb_sysid_check_ctrl;

  localparam logic [31:0] ID_V = 32'h2F35ABDF;
  localparam logic [31:0] TS_V = 32'h4D49E0DD;

  logic        clk = 1'b0;
  logic        rst;
  int          errors = 0;
  int          checks = 0;

  logic        a_sid_addr, a_hread, a_haddr, a_hwait, a_hvalid, a_rchk, a_done, a_idok, a_tsok;
  logic [31:0] a_sid_data, a_hdata, a_id_val, a_ts_val;
  logic        b_sid_addr, b_hread, b_haddr, b_hwait, b_hvalid, b_rchk, b_done, b_idok, b_tsok;
  logic [31:0] b_sid_data, b_hdata;
`ifdef SYSID_CHK_ERR_IRQ_EN
  logic        a_irq, a_irq_ack, b_irq, b_irq_ack;
`endif

  always #5 clk = ~clk;

  // Combinational system-ID slave models.
  assign a_sid_data = a_sid_addr ? a_ts_val : a_id_val;
  assign b_sid_data = b_sid_addr ? TS_V : ID_V;

  sysid_check_ctrl #(.RD_WAIT(1)) dut_a (
    .clock_i(clk), .reset_i(rst), .sid_address_o(a_sid_addr), .sid_readdata_i(a_sid_data),
    .host_read_i(a_hread), .host_address_i(a_haddr), .host_waitrequest_o(a_hwait),
    .host_readdata_o(a_hdata), .host_readdatavalid_o(a_hvalid), .recheck_i(a_rchk),
    .check_done_o(a_done), .id_ok_o(a_idok),
`ifdef SYSID_CHK_ERR_IRQ_EN
    .ts_ok_o(a_tsok), .irq_o(a_irq), .irq_ack_i(a_irq_ack)
`else
    .ts_ok_o(a_tsok)
`endif
  );

  sysid_check_ctrl #(.RD_WAIT(2)) dut_b (
    .clock_i(clk), .reset_i(rst), .sid_address_o(b_sid_addr), .sid_readdata_i(b_sid_data),
    .host_read_i(b_hread), .host_address_i(b_haddr), .host_waitrequest_o(b_hwait),
    .host_readdata_o(b_hdata), .host_readdatavalid_o(b_hvalid), .recheck_i(b_rchk),
    .check_done_o(b_done), .id_ok_o(b_idok),
`ifdef SYSID_CHK_ERR_IRQ_EN
    .ts_ok_o(b_tsok), .irq_o(b_irq), .irq_ack_i(b_irq_ack)
`else
    .ts_ok_o(b_tsok)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_hread = 0; a_haddr = 0; a_rchk = 0; a_id_val = ID_V; a_ts_val = TS_V;
    b_hread = 0; b_haddr = 0; b_rchk = 0;
`ifdef SYSID_CHK_ERR_IRQ_EN
    a_irq_ack = 0; b_irq_ack = 0;
`endif
    step(2);
    check("rst_sid_addr", a_sid_addr, 0);
    check("rst_hdata",    a_hdata, 0);
    check("rst_hvalid",   a_hvalid, 0);
    check("rst_done",     a_done, 0);
    check("rst_idok",     a_idok, 0);
    check("rst_tsok",     a_tsok, 0);
    check("rst_hwait",    a_hwait, 1);
`ifdef SYSID_CHK_ERR_IRQ_EN
    check("rst_irq",      a_irq, 0);
`endif
    // Release just after edge 0.
    rst = 1'b0;
    step(3);
    check("t1_done_e3",   a_done, 0);
    check("t1_sidaddr_e3", a_sid_addr, 1);
    step(1);
    check("t1_done_e4",   a_done, 1);
    check("t1_idok",      a_idok, 1);
    check("t1_tsok",      a_tsok, 1);
    check("t1_hwait_idle", a_hwait, 0);
    step(1);
    check("b_done_e5",    b_done, 0);
    step(1);
    check("b_done_e6",    b_done, 1);
    check("b_ok",         {b_idok, b_tsok}, 2'b11);

    // Host read on dut_b with RD_WAIT=2.
    b_hread = 1; b_haddr = 1;
    step(1);
    check("t3_hwait_acc", b_hwait, 1);
    check("t3_valid_n",   b_hvalid, 0);
    b_hread = 0;
    step(2);
    check("t3_valid_n2",  b_hvalid, 0);
    step(1);
    check("t3_valid_n3",  b_hvalid, 1);
    check("t3_data",      b_hdata, TS_V);
    step(1);
    check("t3_valid_off", b_hvalid, 0);

    // Timestamp mismatch.
    a_ts_val = 32'h4D49E0DE;
    a_rchk = 1;
    #1;
    check("t2_hwait_rchk", a_hwait, 1);
    step(1);
    a_rchk = 0;
    check("t2_done_clr",  a_done, 0);
    check("t2_idok_clr",  a_idok, 0);
    check("t2_hwait",     a_hwait, 1);
    step(3);
    check("t2_done_r3",   a_done, 0);
    step(1);
    check("t2_done",      a_done, 1);
    check("t2_idok",      a_idok, 1);
    check("t2_tsok",      a_tsok, 0);
`ifdef SYSID_CHK_ERR_IRQ_EN
    check("t2_irq_set",   a_irq, 1);
    step(2);
    check("t2_irq_sticky", a_irq, 1);
    a_irq_ack = 1;
    step(1);
    a_irq_ack = 0;
    check("t2_irq_ack",   a_irq, 0);
`endif
    a_ts_val = TS_V;

    // Recheck and host read in the same idle cycle.
    a_rchk = 1; a_hread = 1; a_haddr = 0;
    #1;
    check("t4_hwait_same", a_hwait, 1);
    step(1);
    a_rchk = 0;
    check("t4_hwait_r0",  a_hwait, 1);
    step(3);
    check("t4_hwait_r3",  a_hwait, 1);
    check("t4_done_r3",   a_done, 0);
    step(1);
    check("t4_done",      a_done, 1);
    check("t4_ok",        {a_idok, a_tsok}, 2'b11);
    check("t4_hwait_free", a_hwait, 0);
    step(1);
    check("t4_hwait_acc", a_hwait, 1);
    a_hread = 0;
    step(1);
    check("t4_valid_early", a_hvalid, 0);
    step(1);
    check("t4_valid",     a_hvalid, 1);
    check("t4_data",      a_hdata, ID_V);

    // Recheck while the host read is in flight.
    a_hread = 1; a_haddr = 1;
    step(1);
    a_hread = 0;
    a_rchk = 1;
    step(1);
    a_rchk = 0;
    check("t5_done_clr",  a_done, 0);
    check("t5_hwait_pend", a_hwait, 1);
    check("t5_valid_n1",  a_hvalid, 0);
    step(1);
    check("t5_valid",     a_hvalid, 1);
    check("t5_data",      a_hdata, TS_V);
    check("t5_hwait_chk", a_hwait, 1);
    step(1);
    check("t5_valid_off", a_hvalid, 0);
    check("t5_sidaddr",   a_sid_addr, 0);
    step(2);
    check("t5_done_mid",  a_done, 0);
    step(1);
    check("t5_done",      a_done, 1);
    check("t5_ok",        {a_idok, a_tsok}, 2'b11);

    // Reset in the middle of the timestamp read.
    a_rchk = 1;
    step(1);
    a_rchk = 0;
    step(2);
    check("t6_in_ts",     a_sid_addr, 1);
    check("t6_idok_pre",  a_idok, 1);
    rst = 1'b1;
    #1;
    check("t6_sidaddr",   a_sid_addr, 0);
    check("t6_idok",      a_idok, 0);
    check("t6_done",      a_done, 0);
    check("t6_b_hdata",   b_hdata, 0);
    check("t6_b_done",    b_done, 0);
    step(1);
    rst = 1'b0;
    step(3);
    check("t6_done_e3",   a_done, 0);
    step(1);
    check("t6_done_e4",   a_done, 1);
    check("t6_ok",        {a_idok, a_tsok}, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
